// File: rtl/sdram_pkg.sv
// Shared types, constants and the priority decision for the SDRAM arbiter.
package sdram_pkg;

  localparam int SDRAM_ADDR_W    = 24;
  localparam int SDRAM_STREAK_MX = 4;
  localparam int SDRAM_STREAK_W  = 3;
  localparam int SDRAM_BURST_LEN = 64;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_VID  = 2'b01,
    GNT_CPU  = 2'b10
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VID,
    ST_CPU,
    ST_TURN
  } arb_state_e;

  // Video wins ties unless the CPU has waited through a full streak.
  function automatic grant_e arb_pick(
    input logic vid,
    input logic cpu,
    input logic starved
  );
    grant_e g;
    g = GNT_NONE;
    if (vid && cpu) g = starved ? GNT_CPU : GNT_VID;
    else if (vid)   g = GNT_VID;
    else if (cpu)   g = GNT_CPU;
    return g;
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-way SDRAM port arbiter: fixed video priority with
// a streak limit so the CPU bridge is never starved.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W         = SDRAM_ADDR_W,
  parameter int VID_STREAK_MAX = SDRAM_STREAK_MX,
  parameter int STREAK_W       = SDRAM_STREAK_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vid_rd_i,
  input  logic [ADDR_W-1:0] vid_addr_x16_i,
  input  logic              vid_ack_i,
  output logic              vid_rdy_o,
  output logic [15:0]       vid_rdata_o,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_x16_i,
  input  logic [15:0]       cpu_wdata_i,
  input  logic [1:0]        cpu_wmask_i,
  input  logic              cpu_ack_i,
  output logic              cpu_rdy_o,
  output logic [15:0]       cpu_rdata_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_x16_o,
  output logic [15:0]       mem_wdata_o,
  output logic [1:0]        mem_wmask_o,
  output logic              mem_ack_o,
  input  logic              mem_rdy_i,
  input  logic [15:0]       mem_rdata_i,
  output logic [1:0]        grant_o
);

  localparam logic [STREAK_W-1:0] SMAX =
    STREAK_W'(VID_STREAK_MAX);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                cpu_req;
  grant_e              pick;

  assign cpu_req = cpu_rd_i | cpu_wr_i;
  assign pick    = arb_pick(vid_rd_i, cpu_req,
                            streak_q == SMAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!cpu_req) streak_d = '0;
        unique case (pick)
          GNT_VID: begin
            state_d = ST_VID;
            if (cpu_req && streak_q != SMAX)
              streak_d = streak_q + STREAK_W'(1);
          end
          GNT_CPU: begin
            state_d  = ST_CPU;
            streak_d = '0;
          end
          default: ;
        endcase
      end
      ST_VID:  if (vid_ack_i) state_d = ST_TURN;
      ST_CPU:  if (cpu_ack_i) state_d = ST_TURN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Requests and data pass straight through from the registered owner.
  always_comb begin
    mem_rd_o       = 1'b0;
    mem_wr_o       = 1'b0;
    mem_addr_x16_o = '0;
    mem_wdata_o    = '0;
    mem_wmask_o    = '0;
    mem_ack_o      = 1'b0;
    vid_rdy_o      = 1'b0;
    vid_rdata_o    = '0;
    cpu_rdy_o      = 1'b0;
    cpu_rdata_o    = '0;
    grant_o        = GNT_NONE;
    unique case (1'b1)
      state_q == ST_VID: begin
        grant_o        = GNT_VID;
        mem_rd_o       = vid_rd_i;
        mem_addr_x16_o = vid_addr_x16_i;
        mem_ack_o      = vid_ack_i;
        vid_rdy_o      = mem_rdy_i;
        vid_rdata_o    = mem_rdata_i;
      end
      state_q == ST_CPU: begin
        grant_o        = GNT_CPU;
        mem_wr_o       = cpu_wr_i;
        mem_rd_o       = cpu_rd_i & ~cpu_wr_i;
        mem_addr_x16_o = cpu_addr_x16_i;
        mem_wdata_o    = cpu_wdata_i;
        mem_wmask_o    = cpu_wmask_i;
        mem_ack_o      = cpu_ack_i;
        cpu_rdy_o      = mem_rdy_i;
        cpu_rdata_o    = mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: bursts, CPU write,
// tie-break, starvation limit, stray ack and async reset.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_rd = 1'b0;
  logic [23:0] vid_addr = '0;
  logic        vid_ack = 1'b0;
  logic        vid_rdy;
  logic [15:0] vid_rdata;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [1:0]  cpu_wmask = '0;
  logic        cpu_ack = 1'b0;
  logic        cpu_rdy;
  logic [15:0] cpu_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wmask;
  logic        mem_ack;
  logic        mem_rdy = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;
  int rdy_cnt = 0;
  int ack_cnt = 0;

  sdram_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .vid_rd_i       (vid_rd),
    .vid_addr_x16_i (vid_addr),
    .vid_ack_i      (vid_ack),
    .vid_rdy_o      (vid_rdy),
    .vid_rdata_o    (vid_rdata),
    .cpu_rd_i       (cpu_rd),
    .cpu_wr_i       (cpu_wr),
    .cpu_addr_x16_i (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_wmask_i    (cpu_wmask),
    .cpu_ack_i      (cpu_ack),
    .cpu_rdy_o      (cpu_rdy),
    .cpu_rdata_o    (cpu_rdata),
    .mem_rd_o       (mem_rd),
    .mem_wr_o       (mem_wr),
    .mem_addr_x16_o (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_wmask_o    (mem_wmask),
    .mem_ack_o      (mem_ack),
    .mem_rdy_i      (mem_rdy),
    .mem_rdata_i    (mem_rdata),
    .grant_o        (grant)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vid_rdy) rdy_cnt++;
    if (mem_ack) ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    int rdy0;
    int ack0;
    int mstreak;
    grant_e g;

    // reset state
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_ack", 32'(mem_ack), 32'h0);
    chk("rst_streak", 32'(dut.streak_q), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // video-only burst
    rdy0 = rdy_cnt;
    ack0 = ack_cnt;
    vid_rd = 1'b1;
    vid_addr = 24'h080000;
    #1;
    chk("vid_pre_grant", 32'(grant), 32'h0);
    chk("vid_pre_rd", 32'(mem_rd), 32'h0);
    tick();
    chk("vid_grant", 32'(grant), 32'h1);
    chk("vid_mem_rd", 32'(mem_rd), 32'h1);
    chk("vid_addr", 32'(mem_addr), 32'h080000);
    for (int i = 0; i < SDRAM_BURST_LEN; i++) begin
      mem_rdy = 1'b1;
      mem_rdata = 16'hA500 ^ 16'(i);
      if (i == 5) begin
        #1;
        chk("vid_rdata", 32'(vid_rdata), 32'hA505);
        chk("vid_cpu_rdy", 32'(cpu_rdy), 32'h0);
      end
      tick();
    end
    mem_rdy = 1'b0;
    vid_ack = 1'b1;
    #1;
    chk("vid_ack_fwd", 32'(mem_ack), 32'h1);
    tick();
    vid_ack = 1'b0;
    vid_rd = 1'b0;
    #1;
    chk("turn_mem_rd", 32'(mem_rd), 32'h0);
    chk("turn_grant", 32'(grant), 32'h0);
    chk("vid_rdy_cnt", 32'(rdy_cnt - rdy0), 32'd64);
    chk("vid_ack_cnt", 32'(ack_cnt - ack0), 32'd1);
    tick();
    chk("idle_grant", 32'(grant), 32'h0);

    // CPU write
    rdy0 = rdy_cnt;
    cpu_wr = 1'b1;
    cpu_addr = 24'h000123;
    cpu_wdata = 16'hBEEF;
    cpu_wmask = 2'b11;
    tick();
    chk("cpu_grant", 32'(grant), 32'h2);
    chk("cpu_mem_wr", 32'(mem_wr), 32'h1);
    chk("cpu_mem_rd", 32'(mem_rd), 32'h0);
    chk("cpu_addr", 32'(mem_addr), 32'h123);
    chk("cpu_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("cpu_wmask", 32'(mem_wmask), 32'h3);
    mem_rdy = 1'b1;
    #1;
    chk("cpu_rdy", 32'(cpu_rdy), 32'h1);
    chk("cpu_vid_rdy", 32'(vid_rdy), 32'h0);
    tick();
    mem_rdy = 1'b0;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_wr = 1'b0;
    #1;
    chk("cpu_turn_wr", 32'(mem_wr), 32'h0);
    chk("cpu_no_vid_rdy", 32'(rdy_cnt - rdy0), 32'd0);
    tick();

    // simultaneous requests, streak 0
    vid_rd = 1'b1;
    cpu_rd = 1'b1;
    cpu_addr = 24'h000456;
    g = arb_pick(1'b1, 1'b1, 1'b0);
    tick();
    chk("tie_grant", 32'(grant), 32'(g));
    chk("tie_streak", 32'(dut.streak_q), 32'd1);
    vid_ack = 1'b1;
    tick();
    vid_ack = 1'b0;
    vid_rd = 1'b0;
    #1;
    chk("tie_turn", 32'(grant), 32'h0);
    tick();
    chk("tie_idle", 32'(grant), 32'h0);
    tick();
    chk("tie_cpu_grant", 32'(grant), 32'h2);
    chk("tie_cpu_rd", 32'(mem_rd), 32'h1);
    chk("tie_cpu_addr", 32'(mem_addr), 32'h456);
    chk("tie_streak0", 32'(dut.streak_q), 32'd0);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_rd = 1'b0;
    tick();

    // starvation limit: 4 video bursts, then CPU
    mstreak = 0;
    vid_rd = 1'b1;
    cpu_rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = arb_pick(1'b1, 1'b1, mstreak == 4);
      mstreak++;
      tick();
      chk($sformatf("starve_vid%0d", k),
          32'(grant), 32'(g));
      chk($sformatf("starve_streak%0d", k),
          32'(dut.streak_q), 32'(mstreak));
      vid_ack = 1'b1;
      tick();
      vid_ack = 1'b0;
      tick();
    end
    g = arb_pick(1'b1, 1'b1, mstreak == 4);
    tick();
    chk("starve_cpu_grant", 32'(grant), 32'(g));
    chk("starve_streak_clr", 32'(dut.streak_q), 32'd0);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_rd = 1'b0;
    vid_rd = 1'b0;
    tick();

    // stray CPU ack while video owns
    vid_rd = 1'b1;
    vid_addr = 24'h0A0000;
    tick();
    cpu_ack = 1'b1;
    #1;
    chk("stray_no_ack", 32'(mem_ack), 32'h0);
    tick();
    cpu_ack = 1'b0;
    chk("stray_grant", 32'(grant), 32'h1);

    // reset after 10 words of the burst
    for (int i = 0; i < 10; i++) begin
      mem_rdy = 1'b1;
      mem_rdata = 16'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("arst_mem_rd", 32'(mem_rd), 32'h0);
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_vid_rdy", 32'(vid_rdy), 32'h0);
    chk("arst_rdata", 32'(vid_rdata), 32'h0);
    mem_rdy = 1'b0;
    vid_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    cpu_rd = 1'b1;
    cpu_addr = 24'h000789;
    #1;
    chk("post_rst_idle", 32'(grant), 32'h0);
    tick();
    chk("post_rst_cpu", 32'(grant), 32'h2);
    chk("post_rst_addr", 32'(mem_addr), 32'h789);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_rd = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
